// File: rtl/taylor_trig_engine_if.sv
// Start/ready handshake bundle for the Taylor trig engine: request side (start, mode, x)
// and result side (ans, ready, busy).
interface taylor_trig_engine_if #(
    parameter int W = 16
);
    logic         start;
    logic         mode;
    logic [W-1:0] x;
    logic [W-1:0] ans;
    logic         ready;
    logic         busy;

    modport master (output start, mode, x, input ans, ready, busy);
    modport slave  (input start, mode, x, output ans, ready, busy);
endinterface

// File: rtl/taylor_trig_engine.sv
// Iterative Taylor-series cos/sin evaluator for signed Q(W-F).F angles. One shared multiplier
// steps through square, term*x^2 and reciprocal-factorial scaling; the result is clamped to +/-1.0.
//   state  | meaning
//   IDLE   | waiting for start; ans held
//   SQR    | x2 = x*x >>> F
//   MUL1   | t = term*x2 >>> F
//   MUL2   | term = -(t*RECIP >>> W), accumulate, advance k
//   DONE   | ready pulse, ans valid
module taylor_trig_engine #(
    parameter int W     = 16,
    parameter int F     = 8,
    parameter int TERMS = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    taylor_trig_engine_if.slave   bus
);
    localparam int PW = 2 * W + 2;
    localparam int AW = W + 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SQR  = 3'd1;
    localparam logic [2:0] S_MUL1 = 3'd2;
    localparam logic [2:0] S_MUL2 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic signed [AW-1:0] ONE     = AW'(1 << F);
    localparam logic signed [AW-1:0] NEG_ONE = -ONE;

    // round(2^W / d), where d is the product of the two next factorial factors
    function automatic logic [W:0] recip_f(input int m, input int k);
        longint d;
        d = (m != 0) ? longint'((2 * k + 2) * (2 * k + 3)) : longint'((2 * k + 1) * (2 * k + 2));
        return (W + 1)'(((longint'(1) <<< (W + 1)) + d) / (2 * d));
    endfunction

    localparam logic [W:0] RECIP_C [8] = '{recip_f(0, 0), recip_f(0, 1), recip_f(0, 2), recip_f(0, 3),
                                           recip_f(0, 4), recip_f(0, 5), recip_f(0, 6), recip_f(0, 7)};
    localparam logic [W:0] RECIP_S [8] = '{recip_f(1, 0), recip_f(1, 1), recip_f(1, 2), recip_f(1, 3),
                                           recip_f(1, 4), recip_f(1, 5), recip_f(1, 6), recip_f(1, 7)};

    logic [2:0]              r_state;
    logic                    r_mode;
    logic signed [W-1:0]     r_x;
    logic signed [W-1:0]     r_x2;
    logic signed [AW-1:0]    r_term;
    logic signed [AW-1:0]    r_t;
    logic signed [AW-1:0]    r_acc;
    logic [2:0]              r_k;
    logic [W-1:0]            r_ans;
    logic                    r_ready;
    logic                    r_busy;

    logic [W:0]              w_recip;
    logic signed [PW-1:0]    w_op_a;
    logic signed [PW-1:0]    w_op_b;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_shf_f;
    logic signed [PW-1:0]    w_shf_w;
    logic signed [AW-1:0]    w_term_nxt;
    logic signed [AW-1:0]    w_acc_nxt;
    logic signed [AW-1:0]    w_sat;
    logic                    w_last;
    logic                    w_unused;

    assign w_recip = r_mode ? RECIP_S[r_k] : RECIP_C[r_k];

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_SQR: begin
                w_op_a = {{(PW-W){r_x[W-1]}}, r_x};
                w_op_b = {{(PW-W){r_x[W-1]}}, r_x};
            end
            S_MUL1: begin
                w_op_a = {{(PW-AW){r_term[AW-1]}}, r_term};
                w_op_b = {{(PW-W){r_x2[W-1]}}, r_x2};
            end
            S_MUL2: begin
                w_op_a = {{(PW-AW){r_t[AW-1]}}, r_t};
                w_op_b = {{(PW-W-1){1'b0}}, w_recip};
            end
            default: begin
                w_op_a = '0;
                w_op_b = '0;
            end
        endcase
    end

    assign w_prod     = w_op_a * w_op_b;
    assign w_shf_f    = w_prod >>> F;
    assign w_shf_w    = w_prod >>> W;
    assign w_term_nxt = -w_shf_w[AW-1:0];
    assign w_acc_nxt  = r_acc + w_term_nxt;
    assign w_last     = (r_k == 3'(TERMS - 2));

    always_comb begin
        w_sat = w_acc_nxt;
        if (w_acc_nxt > ONE)
            w_sat = ONE;
        else if (w_acc_nxt < NEG_ONE)
            w_sat = NEG_ONE;
    end

    assign w_unused = ^{w_shf_f[PW-1:AW], w_shf_w[PW-1:AW], w_sat[AW-1:W]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_x2    <= '0;
            r_term  <= '0;
            r_t     <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_ans   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x     <= bus.x;
                        r_mode  <= bus.mode;
                        r_term  <= bus.mode ? {{2{bus.x[W-1]}}, bus.x} : ONE;
                        r_acc   <= bus.mode ? {{2{bus.x[W-1]}}, bus.x} : ONE;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SQR;
                    end
                end
                S_SQR: begin
                    r_x2    <= w_shf_f[W-1:0];
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    r_t     <= w_shf_f[AW-1:0];
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_term <= w_term_nxt;
                    r_acc  <= w_acc_nxt;
                    r_k    <= r_k + 3'd1;
                    if (w_last) begin
                        r_ans   <= w_sat[W-1:0];
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MUL1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ans   = r_ans;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
endmodule

// File: tb/tb_taylor_trig_engine.sv
// Bench for taylor_trig_engine: TERMS=6 and TERMS=4 builds driven in parallel, checked against
// a plain-arithmetic series model, spec accuracy windows, latency and handshake corner cases.
module tb_taylor_trig_engine;
    localparam int W = 16;
    localparam int F = 8;

    logic clk;
    logic rst_n;
    logic start;
    logic mode;
    logic [W-1:0] x;

    int n_pass = 0;
    int n_tot  = 0;

    taylor_trig_engine_if #(.W(W)) u_if6 ();
    taylor_trig_engine_if #(.W(W)) u_if4 ();

    assign u_if6.start = start;
    assign u_if6.mode  = mode;
    assign u_if6.x     = x;
    assign u_if4.start = start;
    assign u_if4.mode  = mode;
    assign u_if4.x     = x;

    taylor_trig_engine #(.W(W), .F(F), .TERMS(6)) u_dut6 (.i_clk(clk), .i_rst_n(rst_n), .bus(u_if6));
    taylor_trig_engine #(.W(W), .F(F), .TERMS(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(u_if4));

    always #5 clk = ~clk;

    // Series evaluated straight from the definition with wide integers.
    function automatic longint model(input bit m, input longint xv, input int terms);
        longint x2, term, acc, t, d, r;
        x2   = (xv * xv) >>> F;
        term = m ? xv : (longint'(1) <<< F);
        acc  = term;
        for (int k = 0; k < terms - 1; k++) begin
            t    = (term * x2) >>> F;
            d    = m ? longint'((2 * k + 2) * (2 * k + 3)) : longint'((2 * k + 1) * (2 * k + 2));
            r    = ((longint'(1) <<< (W + 1)) + d) / (2 * d);
            term = -((t * r) >>> W);
            acc  = acc + term;
        end
        if (acc > 256) acc = 256;
        if (acc < -256) acc = -256;
        return acc;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    endtask

    logic signed [W-1:0] a6, a4;
    int lat6, lat4, bc;
    logic post_busy, post_ready;
    logic signed [W-1:0] post_ans;

    // One request, then scramble inputs to show they are not re-sampled in flight.
    task automatic run_op(input bit m, input logic signed [W-1:0] xv);
        @(negedge clk);
        start = 1'b1; mode = m; x = xv;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); x = W'($urandom);
        lat6 = -1; lat4 = -1; bc = 0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (lat6 >= 0 && n == lat6 + 1) begin
                post_busy  = u_if6.busy;
                post_ready = u_if6.ready;
                post_ans   = u_if6.ans;
            end
            if (u_if6.busy) bc++;
            if (u_if6.ready && lat6 < 0) begin lat6 = n; a6 = u_if6.ans; end
            if (u_if4.ready && lat4 < 0) begin lat4 = n; a4 = u_if4.ans; end
            if (lat6 >= 0 && lat4 >= 0 && n > lat6) break;
        end
    endtask

    task automatic check_op(input string tag, input bit m, input logic signed [W-1:0] xv);
        longint e6, e4;
        e6 = model(m, longint'(xv), 6);
        e4 = model(m, longint'(xv), 4);
        run_op(m, xv);
        chk({tag, "_lat6"}, lat6, 11);
        chk({tag, "_lat4"}, lat4, 7);
        chk({tag, "_ans6"}, longint'(a6), e6);
        chk({tag, "_ans4"}, longint'(a4), e4);
        chk({tag, "_busy_cycles"}, bc, 12);
        chk({tag, "_busy_drop"}, longint'(post_busy), 0);
        chk({tag, "_ready_pulse"}, longint'(post_ready), 0);
        chk({tag, "_ans_held"}, longint'(post_ans), e6);
    endtask

    typedef struct {
        bit m;
        int xv;
        int lo;
        int hi;
    } vec_t;

    vec_t vecs[6];
    int rdy_cnt, first_rdy, second_rdy;
    logic signed [W-1:0] xr;

    initial begin
        vecs[0] = '{1'b0,    0,  256,  256};
        vecs[1] = '{1'b1,    0,    0,    0};
        vecs[2] = '{1'b1,  402,  254,  256};
        vecs[3] = '{1'b0,  402,   -2,    2};
        vecs[4] = '{1'b1, -201, -184, -178};
        vecs[5] = '{1'b0,  804, -256, -253};

        clk = 1'b0; rst_n = 1'b0; start = 1'b0; mode = 1'b0; x = '0;
        repeat (3) @(negedge clk);
        chk("rst_ans", longint'(u_if6.ans), 0);
        chk("rst_ready", longint'(u_if6.ready), 0);
        chk("rst_busy", longint'(u_if6.busy), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            check_op($sformatf("tbl%0d", i), vecs[i].m, W'(vecs[i].xv));
            chk_rng($sformatf("tbl%0d_window", i), longint'(a6), vecs[i].lo, vecs[i].hi);
        end
        run_op(1'b1, 16'sd402);
        chk_rng("t4_sin_pi2_window", longint'(a4), 251, 259);

        for (int i = 0; i < 16; i++) begin
            xr = W'(int'($urandom_range(2000)) - 1000);
            check_op($sformatf("rnd%0d", i), 1'($urandom), xr);
        end

        // Extra starts mid-computation and in the DONE cycle must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x = 16'sd300;
        rdy_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (u_if6.ready) begin
                rdy_cnt++;
                chk("busy_start_ready_at", n, 11);
            end
            start = (n == 4 || n == 11);
            mode  = 1'b1;
            x     = 16'sd123;
        end
        chk("busy_start_ready_count", rdy_cnt, 1);
        chk("busy_start_ans", longint'($signed(u_if6.ans)), model(1'b0, 300, 6));
        chk("busy_start_idle", longint'(u_if6.busy), 0);

        // Held start re-triggers right after DONE.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x = '0;
        first_rdy = -1; second_rdy = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (u_if6.ready) begin
                if (first_rdy < 0) first_rdy = n;
                else if (second_rdy < 0) second_rdy = n;
            end
        end
        start = 1'b0;
        chk("held_first_ready", first_rdy, 11);
        chk("held_retrigger_gap", second_rdy - first_rdy, 13);
        chk("held_ans", longint'($signed(u_if6.ans)), 256);
        for (int n = 0; n < 20 && u_if6.busy; n++) @(negedge clk);
        chk("held_drain_busy", longint'(u_if6.busy), 0);

        // Async reset while in MUL1 aborts and clears outputs immediately.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; x = 16'sd500;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ans", longint'(u_if6.ans), 0);
        chk("abort_busy", longint'(u_if6.busy), 0);
        chk("abort_ready", longint'(u_if6.ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_rst", 1'b0, 16'sd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
